usr1_mul_nios: RTL

- Multi-cycle Nios custom-instruction slave that performs signed or unsigned WIDTH x WIDTH multiplication.
- It is the multiply counterpart of the team's shift-subtract divider instruction and uses radix-2 shift-add over magnitudes with a final sign correction.
- It returns either half of the 2*WIDTH product, selected by the instruction n field.
- It sits on the CPU custom-instruction port beside the divider and is used by the enet firmware for checksum and scaling math.

---
 rtl/usr1_mul_nios.sv | 112 +++++++++++
 1 files changed

// File: rtl/usr1_mul_nios.sv
// Multi-cycle Nios custom-instruction multiplier: radix-2 shift-add over operand
// magnitudes, sign-corrected at the end, returning the high or low product word.
module usr1_mul_nios #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic [1:0]       n,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      count, count_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  logic [2*WIDTH:0]   p, p_nxt;          // {carry, hi, lo}
  logic               neg, neg_nxt;
  logic [1:0]         n_q, n_nxt;
  logic               done_nxt;
  logic [WIDTH-1:0]   result_nxt;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Signed mode works on magnitudes; 0x80..0 negates to itself and is read as unsigned.
  assign sgn   = ~n[1];
  assign mag_a = (sgn && dataa[WIDTH-1]) ? ({WIDTH{1'b0}} - dataa) : dataa;
  assign mag_b = (sgn && datab[WIDTH-1]) ? ({WIDTH{1'b0}} - datab) : datab;

  assign sum  = p[0] ? ({1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand})
                     : {1'b0, p[2*WIDTH-1:WIDTH]};
  assign prod = neg ? ({(2*WIDTH){1'b0}} - p[2*WIDTH-1:0]) : p[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (count == CW'(1)) state_nxt = FINISH;
        FINISH:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    count_nxt  = count;
    mcand_nxt  = mcand;
    p_nxt      = p;
    neg_nxt    = neg;
    n_nxt      = n_q;
    done_nxt   = done;
    result_nxt = result;
    if (start) begin
      mcand_nxt = mag_a;
      p_nxt     = {1'b0, {WIDTH{1'b0}}, mag_b};
      count_nxt = CW'(WIDTH);
      neg_nxt   = sgn & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
      n_nxt     = n;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        RUN: begin
          p_nxt     = {1'b0, sum, p[WIDTH-1:1]};
          count_nxt = count - CW'(1);
        end
        FINISH: begin
          result_nxt = n_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
          done_nxt   = 1'b1;
        end
        default: done_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      mcand  <= '0;
      p      <= '0;
      neg    <= 1'b0;
      n_q    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      count  <= count_nxt;
      mcand  <= mcand_nxt;
      p      <= p_nxt;
      neg    <= neg_nxt;
      n_q    <= n_nxt;
      done   <= done_nxt;
      result <= result_nxt;
    end
  end

endmodule
